// File: rtl/improved_dr_ald_16_pipe_if.sv
// Valid/ready operand and result bundle for the approximate log divider.
// The master drives operands and result-ready; the slave is the divider.
interface improved_dr_ald_16_pipe_if;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_a;
   logic [15:0] i_b;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_q;
   logic        o_dz;

   modport master (
      output i_valid, i_a, i_b, i_ready,
      input  o_ready, o_valid, o_q, o_dz
   );

   modport slave (
      input  i_valid, i_a, i_b, i_ready,
      output o_ready, o_valid, o_q, o_dz
   );
endinterface

// File: rtl/improved_dr_ald_16_pipe.sv
// 3-stage Mitchell log divider: signed 16/16 -> signed Q16.16 with divide-by-zero flag.
// Optional macro ALD_ERRCOMP_EN adds a 1-LSB mantissa correction from the truncated remainders.
module improved_dr_ald_16_pipe #(
   parameter int M_WIDTH = 10
) (
   input logic                     i_clk,
   input logic                     i_rst_n,
   improved_dr_ald_16_pipe_if.slave bus
);

   localparam int REM_WIDTH = 15 - M_WIDTH;
   localparam int FD_WIDTH  = M_WIDTH + 2;

   typedef struct packed {
      logic a_zero;
      logic b_zero;
      logic a_neg;
      logic sign_q;
   } flags_t;

   typedef struct packed {
      logic [3:0]         k_a;
      logic [3:0]         k_b;
      logic [M_WIDTH-1:0] f_a;
      logic [M_WIDTH-1:0] f_b;
      flags_t             fl;
   } s1_t;

   typedef struct packed {
      logic [5:0]  e;
      logic [15:0] m;
      flags_t      fl;
   } s2_t;

   function automatic logic [15:0] abs16(input logic [15:0] v);
      // -32768 maps to 0x8000, which is exactly its magnitude read as unsigned.
      return v[15] ? 16'(-v) : v;
   endfunction

   function automatic logic [3:0] lead_one(input logic [15:0] v);
      logic [3:0] pos;
      pos = '0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) pos = 4'(i);
      end
      return pos;
   endfunction

   logic        en;
   logic        v1_q, v2_q, v3_q;
   s1_t         s1_c, s1_q;
   s2_t         s2_c, s2_q;
   logic [31:0] q_c, q3_q;
   logic        dz_c, dz3_q;

   assign en          = !v3_q || bus.i_ready;
   assign bus.o_ready = en;
   assign bus.o_valid = v3_q;
   assign bus.o_q     = q3_q;
   assign bus.o_dz    = dz3_q;

   // ---------------- S1: sign, magnitude, leading one, normalise ----------------
   logic [15:0] mag_a_c, mag_b_c, norm_a_c, norm_b_c;

   always_comb begin
      // NOTE: every combinational output gets a value before any branch so no latch is inferred.
      s1_c     = '0;
      mag_a_c  = abs16(bus.i_a);
      mag_b_c  = abs16(bus.i_b);
      s1_c.k_a = lead_one(mag_a_c);
      s1_c.k_b = lead_one(mag_b_c);
      norm_a_c = mag_a_c << (4'd15 - s1_c.k_a);
      norm_b_c = mag_b_c << (4'd15 - s1_c.k_b);
      s1_c.f_a = M_WIDTH'(norm_a_c >> REM_WIDTH);
      s1_c.f_b = M_WIDTH'(norm_b_c >> REM_WIDTH);
      s1_c.fl.a_zero = (bus.i_a == 16'd0);
      s1_c.fl.b_zero = (bus.i_b == 16'd0);
      s1_c.fl.a_neg  = bus.i_a[15];
      s1_c.fl.sign_q = bus.i_a[15] ^ bus.i_b[15];
   end

`ifdef ALD_ERRCOMP_EN
   localparam int RW = (REM_WIDTH > 0) ? REM_WIDTH : 1;
   logic [RW-1:0] rem_a_c, rem_b_c, rem_a_q, rem_b_q;

   assign rem_a_c = norm_a_c[RW-1:0];
   assign rem_b_c = norm_b_c[RW-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rem_a_q <= '0;
         rem_b_q <= '0;
      end else if (en) begin
         rem_a_q <= rem_a_c;
         rem_b_q <= rem_b_c;
      end
   end
`endif

   // ---------------- S2: log subtraction ----------------
   logic signed [4:0]          kd_c;
   logic signed [FD_WIDTH-1:0] fd_c;

   always_comb begin
      s2_c = '0;
      kd_c = $signed({1'b0, s1_q.k_a}) - $signed({1'b0, s1_q.k_b});
      fd_c = $signed({2'b00, s1_q.f_a}) - $signed({2'b00, s1_q.f_b});
`ifdef ALD_ERRCOMP_EN
      if (M_WIDTH < 15 && s1_q.k_a >= 4'd3 && s1_q.k_b >= 4'd3) begin
         if (rem_a_q > rem_b_q)      fd_c = fd_c + $signed(FD_WIDTH'(1));
         else if (rem_a_q < rem_b_q) fd_c = fd_c - $signed(FD_WIDTH'(1));
      end
`endif
      // fd's top two bits are its integer part (-1, 0 or +1): folding that into the
      // exponent leaves fd's fraction bits as the 1.x mantissa in every case.
      s2_c.e  = {kd_c[4], kd_c} + {{4{fd_c[FD_WIDTH-1]}}, fd_c[FD_WIDTH-1:FD_WIDTH-2]};
      s2_c.m  = 16'({1'b1, fd_c[M_WIDTH-1:0]}) << REM_WIDTH;
      s2_c.fl = s1_q.fl;
   end

   // ---------------- S3: antilog, saturation, sign, special cases ----------------
   logic signed [5:0] sh_c;
   logic [5:0]        nsh_c;
   logic [47:0]       mag_c;

   always_comb begin
      sh_c  = $signed(s2_q.e) + 6'sd1;
      nsh_c = 6'(-sh_c);
      if (sh_c < 0) mag_c = {32'd0, s2_q.m} >> nsh_c;
      else          mag_c = {32'd0, s2_q.m} << sh_c[4:0];

      q_c  = '0;
      dz_c = 1'b0;
      if (s2_q.fl.b_zero) begin
         dz_c = 1'b1;
         q_c  = s2_q.fl.a_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else if (s2_q.fl.a_zero) begin
         q_c = '0;
      end else if (!s2_q.fl.sign_q) begin
         q_c = (mag_c >= 48'h8000_0000) ? 32'h7FFF_FFFF : mag_c[31:0];
      end else begin
         q_c = (mag_c > 48'h8000_0000) ? 32'h8000_0000 : -mag_c[31:0];
      end
   end

   // ---------------- Pipeline registers, all gated by the global advance ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: stage data is cleared along with the valid bits so o_q/o_dz read 0 out of reset.
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         s1_q  <= '0;
         s2_q  <= '0;
         q3_q  <= '0;
         dz3_q <= 1'b0;
      end else if (en) begin
         // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
         v1_q  <= bus.i_valid;
         s1_q  <= s1_c;
         v2_q  <= v1_q;
         s2_q  <= s2_c;
         v3_q  <= v2_q;
         q3_q  <= q_c;
         dz3_q <= dz_c;
      end
   end

endmodule
